bn_param_loader: RTL and testbench

Streaming writer for the batch-normalization stage's per-element parameters. Accepts a word-serial stream of gamma, moving-mean and denominator values over a valid/ready handshake and assembles them into the three flat parameter buses that feed the batch-normalization array. Asserts a valid flag once all three buses are completely and consistently loaded. Sits between the weight/parameter memory reader and the batch-normalization array.

---
 rtl/bn_param_loader.sv | 149 ++++++++++++++
 tb/tb_bn_param_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_loader.sv
// bn_param_loader: word-serial writer for the batch-normalization parameter buses.
// A load streams ELEMENTS gamma words, then ELEMENTS moving-mean words, then ELEMENTS
// denominator words. Each word lands in its own element of the matching flat bus.
// params_valid_o is raised once a complete load has finished.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   start_i                      pulse; begins or restarts a full load
//   word_i / word_valid_i        incoming parameter word and its valid flag
//   word_ready_o                 loader accepts a word this cycle
//   gamma_o                      gamma bus; element i sits at [i*DATA_WIDTH +: DATA_WIDTH]
//   moving_means_o               moving-mean bus; same packing as gamma_o
//   denominators_o               denominator bus; same packing as gamma_o
//   busy_o                       a load is in progress
//   params_valid_o               all three buses are fully loaded
module bn_param_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INPUT      = 30
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start_i,
    input  logic [DATA_WIDTH-1:0]                word_i,
    input  logic                                 word_valid_i,
    output logic                                 word_ready_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]    gamma_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]    moving_means_o,
    output logic [INPUT*INPUT*DATA_WIDTH-1:0]    denominators_o,
    output logic                                 busy_o,
    output logic                                 params_valid_o
);

    localparam int unsigned ELEMENTS = INPUT * INPUT;
    localparam int unsigned BUS_W    = ELEMENTS * DATA_WIDTH;
    localparam int unsigned IDX_W    = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMENTS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_GAMMA = 3'd1,
        LOAD_MEAN  = 3'd2,
        LOAD_DENOM = 3'd3,
        DONE       = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BUS_W-1:0]   gamma_q, gamma_d;
    logic [BUS_W-1:0]   mean_q, mean_d;
    logic [BUS_W-1:0]   denom_q, denom_d;
    logic               ready_q, busy_q, valid_q;
    logic               wr_gamma_c, wr_mean_c, wr_denom_c;

    // Next-state and beat decode; start_i overrides any beat in the same cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_gamma_c = 1'b0;
        wr_mean_c  = 1'b0;
        wr_denom_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = LOAD_GAMMA;
                    idx_d   = '0;
                end
            end
            LOAD_GAMMA, LOAD_MEAN, LOAD_DENOM: begin
                if (start_i) begin
                    state_d = LOAD_GAMMA;
                    idx_d   = '0;
                end else if (word_valid_i && ready_q) begin
                    wr_gamma_c = (state_q == LOAD_GAMMA);
                    wr_mean_c  = (state_q == LOAD_MEAN);
                    wr_denom_c = (state_q == LOAD_DENOM);
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        case (state_q)
                            LOAD_GAMMA: state_d = LOAD_MEAN;
                            LOAD_MEAN:  state_d = LOAD_DENOM;
                            default:    state_d = DONE;
                        endcase
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Element write: only the addressed element of the addressed bus changes.
    always_comb begin
        gamma_d = gamma_q;
        mean_d  = mean_q;
        denom_d = denom_q;
        for (int e = 0; e < int'(ELEMENTS); e++) begin
            if (idx_q == IDX_W'(e)) begin
                if (wr_gamma_c) gamma_d[e*DATA_WIDTH +: DATA_WIDTH] = word_i;
                if (wr_mean_c)  mean_d[e*DATA_WIDTH +: DATA_WIDTH]  = word_i;
                if (wr_denom_c) denom_d[e*DATA_WIDTH +: DATA_WIDTH] = word_i;
            end
        end
    end

    // State, index and bus registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gamma_q <= '0;
            mean_q  <= '0;
            denom_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gamma_q <= gamma_d;
            mean_q  <= mean_d;
            denom_q <= denom_d;
        end
    end

    // Status flags registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ready_q <= (state_d == LOAD_GAMMA) || (state_d == LOAD_MEAN) ||
                       (state_d == LOAD_DENOM);
            busy_q  <= (state_d == LOAD_GAMMA) || (state_d == LOAD_MEAN) ||
                       (state_d == LOAD_DENOM);
            valid_q <= (state_d == DONE);
        end
    end

    assign word_ready_o   = ready_q;
    assign busy_o         = busy_q;
    assign params_valid_o = valid_q;
    assign gamma_o        = gamma_q;
    assign moving_means_o = mean_q;
    assign denominators_o = denom_q;

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed bench for bn_param_loader (DATA_WIDTH=8, INPUT=2, four elements per bus).
// Each full load pushes its expected bus image into a queue. That entry is popped
// and compared once params_valid_o goes high.
module tb_bn_param_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned IN = 2;
    localparam int unsigned BW = IN * IN * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [DW-1:0] word_i;
    logic          word_valid_i;
    logic          word_ready_o;
    logic [BW-1:0] gamma_o;
    logic [BW-1:0] moving_means_o;
    logic [BW-1:0] denominators_o;
    logic          busy_o;
    logic          params_valid_o;

    bn_param_loader #(.DATA_WIDTH(DW), .INPUT(IN)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .word_i         (word_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .gamma_o        (gamma_o),
        .moving_means_o (moving_means_o),
        .denominators_o (denominators_o),
        .busy_o         (busy_o),
        .params_valid_o (params_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] g;
        logic [BW-1:0] m;
        logic [BW-1:0] d;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Expected image of a full load whose first word is base.
    function automatic exp_t mk(input logic [DW-1:0] base);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.g[k*8 +: 8] = base + 8'(k);
            e.m[k*8 +: 8] = base + 8'(k + 4);
            e.d[k*8 +: 8] = base + 8'(k + 8);
        end
        return e;
    endfunction

    task automatic beats(input logic [DW-1:0] base, input int n, input bit bubble,
                         inout int edges);
        for (int i = 0; i < n; i++) begin
            word_valid_i = 1'b1;
            word_i       = base + 8'(i);
            tick();
            edges++;
            word_valid_i = 1'b0;
            if (bubble && i < n - 1) begin
                tick();
                edges++;
                chk("bubble_busy", 32'(busy_o), 32'd1);
            end
        end
    endtask

    // Bounded wait for params_valid_o, then compare against the scoreboard head.
    task automatic finish_load(input string tag, inout int edges, output int waited);
        exp_t e;
        waited = 0;
        while (!params_valid_o && waited < 16) begin
            tick();
            waited++;
            edges++;
        end
        chk({tag, "_pv"}, 32'(params_valid_o), 32'd1);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_gamma"}, gamma_o, e.g);
            chk({tag, "_mean"},  moving_means_o, e.m);
            chk({tag, "_denom"}, denominators_o, e.d);
        end
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_ready"}, 32'(word_ready_o), 32'd0);
    endtask

    initial begin
        int edges;
        int waited;
        reset        = 1'b1;
        start_i      = 1'b0;
        word_valid_i = 1'b0;
        word_i       = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state.
        chk("rst_gamma", gamma_o, 32'h0);
        chk("rst_mean",  moving_means_o, 32'h0);
        chk("rst_denom", denominators_o, 32'h0);
        chk("rst_ready", 32'(word_ready_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_pv",    32'(params_valid_o), 32'd0);

        // Words offered while idle are ignored.
        word_valid_i = 1'b1;
        word_i       = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", 32'(word_ready_o), 32'd0);
        end
        word_valid_i = 1'b0;
        chk("idle_gamma", gamma_o, 32'h0);
        chk("idle_mean",  moving_means_o, 32'h0);
        chk("idle_denom", denominators_o, 32'h0);

        // Continuous load 0x01..0x0C. Start is sampled at edge s, so params_valid_o must first show in cycle s+13.
        sb.push_back(mk(8'h01));
        pulse_start();
        edges = 0;
        chk("cont_ready", 32'(word_ready_o), 32'd1);
        chk("cont_busy",  32'(busy_o), 32'd1);
        beats(8'h01, 11, 1'b0, edges);
        chk("cont_pv_early", 32'(params_valid_o), 32'd0);
        beats(8'h0C, 1, 1'b0, edges);
        finish_load("cont", edges, waited);
        chk("cont_latency", 32'(edges + 1), 32'd13);
        chk("cont_wait", 32'(waited), 32'd0);

        // Clear the buses so the bubbled load is checked on its own merit.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("clr_gamma", gamma_o, 32'h0);

        // Bubbled load: valid low on every other cycle.
        sb.push_back(mk(8'h01));
        pulse_start();
        edges = 0;
        beats(8'h01, 12, 1'b1, edges);
        finish_load("bubble", edges, waited);
        chk("bubble_wait", 32'(waited), 32'd0);

        // Restart mid-load: 6 beats, then start together with a 0xFF beat.
        pulse_start();
        edges = 0;
        beats(8'h31, 6, 1'b0, edges);
        chk("rs_gamma_part", gamma_o, 32'h34333231);
        chk("rs_mean_part",  moving_means_o, 32'h08073635);
        start_i      = 1'b1;
        word_valid_i = 1'b1;
        word_i       = 8'hFF;
        tick();
        start_i      = 1'b0;
        word_valid_i = 1'b0;
        chk("rs_ff_mean",  moving_means_o, 32'h08073635);
        chk("rs_ff_gamma", gamma_o, 32'h34333231);
        chk("rs_busy",     32'(busy_o), 32'd1);
        chk("rs_pv",       32'(params_valid_o), 32'd0);
        sb.push_back(mk(8'h21));
        edges = 0;
        beats(8'h21, 12, 1'b0, edges);
        finish_load("restart", edges, waited);

        // Full load of 0x01..0x0C, then reload from DONE with one beat.
        sb.push_back(mk(8'h01));
        pulse_start();
        edges = 0;
        beats(8'h01, 12, 1'b0, edges);
        finish_load("full2", edges, waited);
        tick();
        chk("done_hold_pv", 32'(params_valid_o), 32'd1);
        pulse_start();
        chk("reload_pv",    32'(params_valid_o), 32'd0);
        chk("reload_ready", 32'(word_ready_o), 32'd1);
        edges = 0;
        beats(8'h55, 1, 1'b0, edges);
        chk("reload_gamma", gamma_o, 32'h04030255);
        chk("reload_mean",  moving_means_o, 32'h08070605);
        chk("reload_denom", denominators_o, 32'h0C0B0A09);

        // Reset mid-load after five beats in total.
        beats(8'h60, 4, 1'b0, edges);
        chk("mid_mean_part", moving_means_o, 32'h08070663);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_gamma", gamma_o, 32'h0);
        chk("mid_rst_mean",  moving_means_o, 32'h0);
        chk("mid_rst_denom", denominators_o, 32'h0);
        chk("mid_rst_pv",    32'(params_valid_o), 32'd0);
        chk("mid_rst_ready", 32'(word_ready_o), 32'd0);
        chk("mid_rst_busy",  32'(busy_o), 32'd0);
        word_valid_i = 1'b1;
        word_i       = 8'h77;
        tick();
        word_valid_i = 1'b0;
        chk("post_rst_ready", 32'(word_ready_o), 32'd0);
        chk("post_rst_gamma", gamma_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
